// File: rtl/player_turn_if.sv
// Bundle between the game-state controller and the player-turn responder.
// master: controller side (drives beam position, phase code, buttons).
// slave: the player_turn block.
interface player_turn_if #(
  parameter int unsigned NUM_OPTIONS = 4
);
  localparam int unsigned CW = $clog2(NUM_OPTIONS);

  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic [3:0]    state_in;
  logic [1:0]    rotate_in;
  logic          busy_out;
  logic          finished_out;
  logic [CW-1:0] choice_out;
  logic [11:0]   pixel_out;

  modport master (
    output hcount_in, vcount_in, state_in, rotate_in,
    input  busy_out, finished_out, choice_out, pixel_out
  );

  modport slave (
    input  hcount_in, vcount_in, state_in, rotate_in,
    output busy_out, finished_out, choice_out, pixel_out
  );
endinterface

// File: rtl/player_turn.sv
// Player-phase responder: draws a row of option boxes, moves a cursor on
// rotate_in[0], locks on rotate_in[1], flashes the choice and pulses
// finished_out. Optional macro PLAYER_TIMEOUT_EN auto-selects after
// TIMEOUT_FRAMES idle frames in ACTIVE.
module player_turn #(
  parameter logic [3:0]  STATE_CODE     = 4'b0001,
  parameter int unsigned NUM_OPTIONS    = 4,
  parameter int unsigned BOX_X0         = 64,
  parameter int unsigned BOX_PITCH      = 144,
  parameter int unsigned BOX_W          = 128,
  parameter int unsigned BOX_Y          = 384,
  parameter int unsigned BOX_H          = 64,
  parameter int unsigned FLASH_FRAMES   = 30,
  parameter int unsigned TIMEOUT_FRAMES = 600
) (
  input logic         clk,
  input logic         rst,
  player_turn_if.slave bus
);
  localparam int unsigned CW = $clog2(NUM_OPTIONS);
  // flash_cnt[2] drives the blink, so keep at least 3 bits
  localparam int unsigned FW = ($clog2(FLASH_FRAMES) < 3) ? 3 : $clog2(FLASH_FRAMES);

  typedef enum logic [2:0] {StIdle, StActive, StFlash, StDone, StWait} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cursor_q, cursor_d;
  logic [CW-1:0]    choice_q, choice_d;
  logic [FW-1:0]    flash_cnt_q, flash_cnt_d;
  logic [1:0]       btn_prev_q;
  logic             busy_q, finished_q;
  logic [11:0]      pixel_q, pixel_d;
  logic [1:0]       btn_edge;
  logic             frame_tick, code_match, timeout;
  logic [11:0]      hx, vy;
  logic [NUM_OPTIONS-1:0] in_box;

  assign btn_edge   = bus.rotate_in & ~btn_prev_q;
  assign frame_tick = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
  assign code_match = (bus.state_in == STATE_CODE);

`ifdef PLAYER_TIMEOUT_EN
  localparam int unsigned IW = ($clog2(TIMEOUT_FRAMES) < 1) ? 1 : $clog2(TIMEOUT_FRAMES);
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  assign timeout = (state_q == StActive) && frame_tick &&
                   (idle_cnt_q == IW'(TIMEOUT_FRAMES - 1));

  // Idle frame counter: cleared on ACTIVE entry and on any button edge
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q == StIdle && code_match) begin
      idle_cnt_d = '0;
    end else if (state_q == StActive) begin
      if (|btn_edge)       idle_cnt_d = '0;
      else if (frame_tick) idle_cnt_d = idle_cnt_q + IW'(1);
    end
  end

  // Idle counter register
  always_ff @(posedge clk) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_FRAMES;
  assign timeout = 1'b0;
`endif

  // Next-state logic; losing the phase code in ACTIVE/FLASH aborts to IDLE
  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    choice_d    = choice_q;
    flash_cnt_d = flash_cnt_q;
    case (state_q)
      StIdle: begin
        if (code_match) begin
          state_d     = StActive;
          cursor_d    = '0;
          flash_cnt_d = '0;
        end
      end
      StActive: begin
        if (!code_match) begin
          state_d = StIdle;
        end else if (btn_edge[1] || timeout) begin
          state_d     = StFlash;
          flash_cnt_d = '0;
        end else if (btn_edge[0]) begin
          cursor_d = (cursor_q == CW'(NUM_OPTIONS - 1)) ? '0 : cursor_q + CW'(1);
        end
      end
      StFlash: begin
        if (!code_match) begin
          state_d = StIdle;
        end else if (frame_tick) begin
          if (flash_cnt_q == FW'(FLASH_FRAMES - 1)) begin
            state_d  = StDone;
            // loaded on DONE entry so it is already valid with finished_out
            choice_d = cursor_q;
          end else begin
            flash_cnt_d = flash_cnt_q + FW'(1);
          end
        end
      end
      StDone:  state_d = StWait;
      StWait:  if (!code_match) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Box hit tests in 12-bit arithmetic
  assign hx = {1'b0, bus.hcount_in};
  assign vy = {2'b00, bus.vcount_in};
  for (genvar i = 0; i < NUM_OPTIONS; i++) begin : g_box
    localparam logic [11:0] X0 = 12'(BOX_X0 + i * BOX_PITCH);
    assign in_box[i] = (hx >= X0) && (hx < X0 + 12'(BOX_W)) &&
                       (vy >= 12'(BOX_Y)) && (vy < 12'(BOX_Y + BOX_H));
  end

  // Pixel colour for the current beam position
  always_comb begin
    pixel_d = 12'h000;
    case (state_q)
      StActive: begin
        if (in_box[cursor_q])  pixel_d = 12'hFF0;
        else if (|in_box)      pixel_d = 12'h888;
      end
      StFlash: begin
        if (in_box[cursor_q])  pixel_d = flash_cnt_q[2] ? 12'hFFF : 12'hFF0;
        else if (|in_box)      pixel_d = 12'h444;
      end
      default: pixel_d = 12'h000;
    endcase
  end

  // State and output registers; busy/finished are registered decodes of state_d
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cursor_q    <= '0;
      choice_q    <= '0;
      flash_cnt_q <= '0;
      btn_prev_q  <= 2'b00;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      pixel_q     <= 12'h000;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      choice_q    <= choice_d;
      flash_cnt_q <= flash_cnt_d;
      btn_prev_q  <= bus.rotate_in;
      busy_q      <= (state_d == StActive) || (state_d == StFlash);
      finished_q  <= (state_d == StDone);
      pixel_q     <= pixel_d;
    end
  end

  assign bus.busy_out     = busy_q;
  assign bus.finished_out = finished_q;
  assign bus.choice_out   = choice_q;
  assign bus.pixel_out    = pixel_q;
endmodule

// File: tb/tb_player_turn.sv
// Directed bench for player_turn: a cycle-by-cycle vector table for cursor
// movement and pixel colours, plus hand sequences for flash, done/wait,
// abort and (with PLAYER_TIMEOUT_EN) the idle auto-select.
module tb_player_turn;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  player_turn_if #(.NUM_OPTIONS(4)) bus ();

  player_turn #(.TIMEOUT_FRAMES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  st;
    logic [1:0]  rot;
    logic [10:0] h;
    logic [9:0]  v;
    logic        busy;
    logic        fin;
    logic [11:0] pix;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [1:0] r,
                       input logic [10:0] h, input logic [9:0] v);
    bus.state_in  = s;
    bus.rotate_in = r;
    bus.hcount_in = h;
    bus.vcount_in = v;
  endtask

  // From FLASH with flash_cnt 0: 30 frame ticks, then 10 hold cycles
  task automatic run_flash(input logic [1:0] exp_choice, input string tag);
    int pulses = 0;
    int fin_at = -1;
    logic [10:0] bx;
    bx = 11'(70 + 144 * int'(exp_choice));
    for (int t = 1; t <= 30; t++) begin
      drive(4'b0001, 2'b00, 11'd0, 10'd0);
      step();
      if (bus.finished_out === 1'b1) begin
        pulses++;
        fin_at = t;
        check({tag, " busy at done"}, 32'(bus.busy_out), 32'd0);
        check({tag, " choice at done"}, 32'(bus.choice_out), 32'(exp_choice));
      end
      if (t == 2 || t == 4) begin
        drive(4'b0001, 2'b01, bx, 10'd400);
        step();
        check($sformatf("%s blink t%0d", tag, t), 32'(bus.pixel_out),
              (t == 4) ? 32'hFFF : 32'hFF0);
      end else begin
        drive(4'b0001, 2'b00, 11'd10, 10'd10);
        step();
      end
      if (bus.finished_out === 1'b1) pulses++;
    end
    for (int k = 0; k < 10; k++) begin
      drive(4'b0001, 2'b00, 11'd10, 10'd10);
      step();
      if (bus.finished_out === 1'b1) pulses++;
    end
    check({tag, " pulse count"}, 32'(pulses), 32'd1);
    check({tag, " pulse tick"}, 32'(fin_at), 32'd30);
    check({tag, " choice held"}, 32'(bus.choice_out), 32'(exp_choice));
    check({tag, " busy in wait"}, 32'(bus.busy_out), 32'd0);
  endtask

  initial begin
    // Cursor walk with a button held on entry, then next+select together at cursor 1
    vecs[0]  = '{4'b0001, 2'b01, 11'd70,  10'd400, 1'b1, 1'b0, 12'h000};
    vecs[1]  = '{4'b0001, 2'b01, 11'd70,  10'd400, 1'b1, 1'b0, 12'hFF0};
    vecs[2]  = '{4'b0001, 2'b00, 11'd214, 10'd400, 1'b1, 1'b0, 12'h888};
    vecs[3]  = '{4'b0001, 2'b01, 11'd214, 10'd400, 1'b1, 1'b0, 12'h888};
    vecs[4]  = '{4'b0001, 2'b00, 11'd214, 10'd400, 1'b1, 1'b0, 12'hFF0};
    vecs[5]  = '{4'b0001, 2'b01, 11'd358, 10'd400, 1'b1, 1'b0, 12'h888};
    vecs[6]  = '{4'b0001, 2'b00, 11'd358, 10'd400, 1'b1, 1'b0, 12'hFF0};
    vecs[7]  = '{4'b0001, 2'b01, 11'd502, 10'd400, 1'b1, 1'b0, 12'h888};
    vecs[8]  = '{4'b0001, 2'b00, 11'd502, 10'd400, 1'b1, 1'b0, 12'hFF0};
    vecs[9]  = '{4'b0001, 2'b01, 11'd70,  10'd400, 1'b1, 1'b0, 12'h888};
    vecs[10] = '{4'b0001, 2'b00, 11'd70,  10'd400, 1'b1, 1'b0, 12'hFF0};
    vecs[11] = '{4'b0001, 2'b01, 11'd214, 10'd400, 1'b1, 1'b0, 12'h888};
    vecs[12] = '{4'b0001, 2'b00, 11'd214, 10'd400, 1'b1, 1'b0, 12'hFF0};
    vecs[13] = '{4'b0001, 2'b11, 11'd214, 10'd400, 1'b1, 1'b0, 12'hFF0};
    vecs[14] = '{4'b0001, 2'b00, 11'd214, 10'd400, 1'b1, 1'b0, 12'hFF0};
    vecs[15] = '{4'b0001, 2'b00, 11'd70,  10'd400, 1'b1, 1'b0, 12'h444};
    vecs[16] = '{4'b0001, 2'b01, 11'd214, 10'd400, 1'b1, 1'b0, 12'hFF0};

    rst = 1'b1;
    drive(4'b0000, 2'b00, 11'd10, 10'd10);
    repeat (3) step();
    check("reset busy", 32'(bus.busy_out), 32'd0);
    check("reset finished", 32'(bus.finished_out), 32'd0);
    check("reset choice", 32'(bus.choice_out), 32'd0);
    check("reset pixel", 32'(bus.pixel_out), 32'h000);
    rst = 1'b0;
    step();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].st, vecs[i].rot, vecs[i].h, vecs[i].v);
      step();
      check($sformatf("vec%0d busy", i), 32'(bus.busy_out), 32'(vecs[i].busy));
      check($sformatf("vec%0d finished", i), 32'(bus.finished_out), 32'(vecs[i].fin));
      check($sformatf("vec%0d pixel", i), 32'(bus.pixel_out), 32'(vecs[i].pix));
    end

    // Both edges together locked cursor 1
    run_flash(2'd1, "both-edges");

    // Leave WAIT via a new phase code
    drive(4'b1000, 2'b00, 11'd70, 10'd400);
    step();
    step();
    check("exit busy", 32'(bus.busy_out), 32'd0);
    check("exit pixel", 32'(bus.pixel_out), 32'h000);

    // Cursor to 2, then select
    drive(4'b0001, 2'b00, 11'd10, 10'd10); step();
    check("reenter busy", 32'(bus.busy_out), 32'd1);
    drive(4'b0001, 2'b01, 11'd10, 10'd10); step();
    drive(4'b0001, 2'b00, 11'd10, 10'd10); step();
    drive(4'b0001, 2'b01, 11'd10, 10'd10); step();
    drive(4'b0001, 2'b00, 11'd10, 10'd10); step();
    drive(4'b0001, 2'b10, 11'd10, 10'd10); step();
    drive(4'b0001, 2'b00, 11'd10, 10'd10); step();
    run_flash(2'd2, "select2");
    drive(4'b0000, 2'b00, 11'd10, 10'd10); step();
    step();

    // Abort from FLASH
    drive(4'b0001, 2'b00, 11'd10, 10'd10); step();
    drive(4'b0001, 2'b01, 11'd10, 10'd10); step();
    drive(4'b0001, 2'b00, 11'd10, 10'd10); step();
    drive(4'b0001, 2'b10, 11'd10, 10'd10); step();
    drive(4'b0001, 2'b00, 11'd214, 10'd400); step();
    check("flash before abort pixel", 32'(bus.pixel_out), 32'hFF0);
    drive(4'b0000, 2'b00, 11'd10, 10'd10); step();
    check("abort busy", 32'(bus.busy_out), 32'd0);
    check("abort finished", 32'(bus.finished_out), 32'd0);
    drive(4'b0000, 2'b00, 11'd214, 10'd400); step();
    check("abort pixel", 32'(bus.pixel_out), 32'h000);
    check("abort choice kept", 32'(bus.choice_out), 32'd2);

`ifdef PLAYER_TIMEOUT_EN
    // Three idle frame ticks auto-select cursor 0
    drive(4'b0001, 2'b00, 11'd10, 10'd10); step();
    for (int t = 0; t < 3; t++) begin
      drive(4'b0001, 2'b00, 11'd0, 10'd0); step();
      drive(4'b0001, 2'b00, 11'd10, 10'd10); step();
    end
    drive(4'b0001, 2'b00, 11'd214, 10'd400); step();
    check("timeout other box", 32'(bus.pixel_out), 32'h444);
    run_flash(2'd0, "timeout");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
